// File: rtl/bldc_commutation.sv
// Six-step BLDC commutation: Hall code -> sector -> U/V phase current refs.
// Registered outputs, one clock of latency, saturating negation.
module bldc_commutation #(
    parameter int REG_SIZE = 16,
    parameter bit REVERSE  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       hall_1,
    input  logic                       hall_2,
    input  logic                       hall_3,
    input  logic signed [REG_SIZE-1:0] current_in,
    output logic signed [REG_SIZE-1:0] current_out_U,
    output logic signed [REG_SIZE-1:0] current_out_V,
    output logic                       hall_error
);

    localparam logic signed [REG_SIZE-1:0] S_MIN =
        {1'b1, {(REG_SIZE-1){1'b0}}};
    localparam logic signed [REG_SIZE-1:0] S_MAX =
        {1'b0, {(REG_SIZE-1){1'b1}}};
    localparam logic signed [REG_SIZE-1:0] S_ZERO = '0;

    // -MIN does not fit, so it clamps to MAX
    function automatic logic signed [REG_SIZE-1:0] neg_sat(
        input logic signed [REG_SIZE-1:0] x
    );
        if (x == S_MIN) begin
            return S_MAX;
        end
        return -x;
    endfunction

    logic [2:0]                 h;
    logic signed [REG_SIZE-1:0] pos_i;
    logic signed [REG_SIZE-1:0] neg_i;
    logic signed [REG_SIZE-1:0] u_tab;
    logic signed [REG_SIZE-1:0] v_tab;
    logic signed [REG_SIZE-1:0] u_nxt;
    logic signed [REG_SIZE-1:0] v_nxt;
    logic                       err_nxt;

    assign h     = {hall_1, hall_2, hall_3};
    assign pos_i = current_in;
    assign neg_i = neg_sat(current_in);

    // Sector lookup; 000 and 111 fall through to the error case
    always_comb begin
        u_tab   = S_ZERO;
        v_tab   = S_ZERO;
        err_nxt = 1'b0;
        unique case (1'b1)
            (h == 3'b101): begin
                u_tab = pos_i;
                v_tab = neg_i;
            end
            (h == 3'b100): begin
                u_tab = pos_i;
            end
            (h == 3'b110): begin
                v_tab = pos_i;
            end
            (h == 3'b010): begin
                u_tab = neg_i;
                v_tab = pos_i;
            end
            (h == 3'b011): begin
                u_tab = neg_i;
            end
            (h == 3'b001): begin
                v_tab = neg_i;
            end
            default: begin
                err_nxt = 1'b1;
            end
        endcase
    end

    // Direction flip after the lookup, then enable gating
    always_comb begin
        u_nxt = u_tab;
        v_nxt = v_tab;
        if (REVERSE) begin
            u_nxt = neg_sat(u_tab);
            v_nxt = neg_sat(v_tab);
        end
        if (!enable) begin
            u_nxt = S_ZERO;
            v_nxt = S_ZERO;
        end
    end

    // Output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            current_out_U <= S_ZERO;
            current_out_V <= S_ZERO;
            hall_error    <= 1'b0;
        end else begin
            current_out_U <= u_nxt;
            current_out_V <= v_nxt;
            hall_error    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bldc_commutation.sv
// Bench for bldc_commutation: directed plan plus random stimulus
// against a coefficient-table reference, forward and reverse instances.
module tb_bldc_commutation;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  h;
    logic [15:0] cur;
    logic [15:0] fu, fv, ru, rv;
    logic        ferr, rerr;

    int n_tests = 0;
    int n_fail  = 0;

    // Phase coefficient per Hall code (index = code), in units of I
    int cu [8] = '{0, 0, -1, -1, 1, 1, 0, 0};
    int cv [8] = '{0, -1, 1, 0, 0, -1, 1, 0};

    always #5 clk = ~clk;

    bldc_commutation #(.REG_SIZE(16), .REVERSE(1'b0)) u_fwd (
        .clk(clk), .rst(rst), .enable(enable),
        .hall_1(h[2]), .hall_2(h[1]), .hall_3(h[0]),
        .current_in(cur),
        .current_out_U(fu), .current_out_V(fv),
        .hall_error(ferr)
    );

    bldc_commutation #(.REG_SIZE(16), .REVERSE(1'b1)) u_rev (
        .clk(clk), .rst(rst), .enable(enable),
        .hall_1(h[2]), .hall_2(h[1]), .hall_3(h[0]),
        .current_in(cur),
        .current_out_U(ru), .current_out_V(rv),
        .hall_error(rerr)
    );

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [15:0] ref_phase(
        input int coef, input logic r, input logic en,
        input logic [15:0] i, input logic rev
    );
        int v;
        if (r || !en) return 16'h0000;
        v = clamp(coef * int'($signed(i)));
        if (rev) v = clamp(-v);
        return v[15:0];
    endfunction

    task automatic step(input logic r, input logic en,
                        input logic [2:0] code, input logic [15:0] i);
        logic [15:0] e_err;
        rst    = r;
        enable = en;
        h      = code;
        cur    = i;
        @(posedge clk);
        #1;
        e_err = (!r && (code == 3'b000 || code == 3'b111)) ? 16'd1 : 16'd0;
        check("fwd_U", fu, ref_phase(cu[code], r, en, i, 1'b0));
        check("fwd_V", fv, ref_phase(cv[code], r, en, i, 1'b0));
        check("fwd_err", {15'd0, ferr}, e_err);
        check("rev_U", ru, ref_phase(cu[code], r, en, i, 1'b1));
        check("rev_V", rv, ref_phase(cv[code], r, en, i, 1'b1));
        check("rev_err", {15'd0, rerr}, e_err);
    endtask

    logic [2:0] sweep [6] = '{3'b101, 3'b100, 3'b110,
                              3'b010, 3'b011, 3'b001};

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        h      = 3'b000;
        cur    = 16'd8;

        // Reset with invalid code, then release
        step(1'b1, 1'b1, 3'b000, 16'd8);
        step(1'b0, 1'b1, 3'b000, 16'd8);

        // Invalid 111 held for several clocks
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 3'b111, 16'd8);

        // Forward sector sweep
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, sweep[k], 16'd8);

        // Enable gating
        step(1'b0, 1'b1, 3'b101, 16'd8);
        step(1'b0, 1'b0, 3'b101, 16'd8);
        step(1'b0, 1'b1, 3'b101, 16'd8);

        // Saturation and negative command
        step(1'b0, 1'b1, 3'b101, 16'h8000);
        check("sat_U", fu, 16'h8000);
        check("sat_V", fv, 16'h7FFF);
        step(1'b0, 1'b1, 3'b010, 16'hFFF8);
        check("neg_U", fu, 16'd8);
        check("neg_V", fv, 16'hFFF8);

        // Reverse table spot check and reset mid-run
        step(1'b0, 1'b1, 3'b100, 16'd8);
        check("rev100_U", ru, 16'hFFF8);
        check("rev100_V", rv, 16'h0000);
        step(1'b1, 1'b1, 3'b100, 16'd8);
        check("rst_mid_U", fu, 16'h0000);
        step(1'b0, 1'b1, 3'b100, 16'd8);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [15:0] i;
            logic        r;
            logic        en;
            case ($urandom_range(0, 7))
                0: i = 16'h8000;
                1: i = 16'h7FFF;
                2: i = 16'hFFFF;
                3: i = 16'h0000;
                default: i = 16'($urandom);
            endcase
            r  = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 7) != 0);
            step(r, en, 3'($urandom), i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bldc_commutation.md
Name: bldc_commutation

Overview:
Six-step (trapezoidal) commutation block for a 3-phase BLDC motor drive. It decodes three Hall sensor inputs into one of six electrical sectors. It routes a signed current command onto phase U and phase V current references; phase W is implied as -(U+V) and is not output. The block sits between the current/speed controller and the phase current loops, and it flags invalid Hall codes.

Parameters:
REG_SIZE, 16, width of the signed two's-complement current command and the phase outputs.
REVERSE, 0, 1 = reverse rotation; both phase outputs are negated relative to the forward table.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  1 = drive the phase outputs; 0 = force the phase outputs to zero.
hall_1  input  1  Hall sensor A; MSB of the Hall code.
hall_2  input  1  Hall sensor B.
hall_3  input  1  Hall sensor C; LSB of the Hall code.
current_in  input  REG_SIZE  signed current magnitude command I.
current_out_U  output  REG_SIZE  signed phase-U current reference.
current_out_V  output  REG_SIZE  signed phase-V current reference.
hall_error  output  1  1 = current Hall code is invalid (000 or 111).

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: current_out_U = 0, current_out_V = 0, hall_error = 0.
- All outputs are registered. Latency is 1 clock from an input change to the output, with no input synchronizer stage.
- Hall code H = {hall_1, hall_2, hall_3}. Each clock it is decoded as follows (U, V; implied W):
  - 101: sector 0 -> U=+I, V=-I (W=0)
  - 100: sector 1 -> U=+I, V=0 (W=-I)
  - 110: sector 2 -> U=0, V=+I (W=-I)
  - 010: sector 3 -> U=-I, V=+I (W=0)
  - 011: sector 4 -> U=-I, V=0 (W=+I)
  - 001: sector 5 -> U=0, V=-I (W=+I)
  - 000 or 111: invalid -> U=0, V=0, hall_error=1
- hall_error is registered every cycle regardless of enable. It is 1 exactly when the previous-cycle H was 000 or 111, otherwise 0. It is not sticky.
- Negation -I is two's complement. If I equals the most negative value (-2^(REG_SIZE-1)), -I saturates to 2^(REG_SIZE-1)-1.
- REVERSE=1: the saturating negation is applied to both table outputs (U and V) after the lookup.
- enable=0: the next-cycle outputs are U=0 and V=0. hall_error is still updated.
- rst has priority over enable and over the Hall inputs.
- Reset mid-operation clears the outputs on that edge; normal decoding resumes on the first edge with rst=0.
- current_in is sampled each clock. A change in I with H unchanged appears on the outputs one cycle later.
- There is no direction/sequence checking. Any valid-to-valid Hall jump is decoded directly.

Test Plan:
- Reset/invalid start: rst=1 for one edge with H=000 and I=8, then rst=0. Outputs read 0/0/0 during reset, then hall_error=1 and U=V=0 one clock after release.
- Invalid 111: H=111 with enable=1 and I=8. Within 2 clocks hall_error=1 and U=V=0; it is still 1 after 25 ns.
- Full sector sweep: enable=1, I=8, H stepped 101,100,110,010,011,001, one per clock. (U,V) follows (8,-8),(8,0),(0,8),(-8,8),(-8,0),(0,-8) with 1-cycle lag, and hall_error=0 throughout.
- Enable gating: H=101, I=8, enable toggled 1->0->1. U/V go 8/-8 -> 0/0 -> 8/-8, each with 1-cycle lag; hall_error stays 0.
- Saturation: I=16'h8000 with H=101. Required U=16'h8000 and V=16'h7FFF. I=-8 with H=010 gives U=8 and V=-8.
- Reverse and reset priority: with REVERSE=1, H=100 and I=8 gives U=-8, V=0. Asserting rst for one edge while driving zeroes all outputs on that edge.
